ow_slave_emu: RTL and testbench
===============================

# ow_slave_emu

Synthesisable emulator of a DS18B20-style 1-Wire temperature slave, parametrised in clock rate, slot timing and conversion time. It samples the bus, answers reset with a presence pulse, decodes Skip ROM / Convert T / Read Scratchpad, and returns a 9-byte scratchpad with Dallas CRC8. It sits beside the 1-Wire master as a bench responder or an on-FPGA loopback target, and replaces hand-timed stimulus blocks.

## Interface

Parameters:
- CLKS_PER_US, 1: clock cycles per microsecond; all timing parameters are in µs and are scaled by this value.
- RESET_MIN_US, 480: minimum low time recognised as a bus reset.
- PRES_WAIT_US, 30: delay from the reset rising edge to the start of presence.
- PRES_LEN_US, 120: length of the presence pulse.
- SAMPLE_US, 30: delay from a slot falling edge to the write-slot sample point.
- READ_HOLD_US, 30: how long a read slot returning 0 holds the bus low.
- CONV_US, 750: conversion time after Convert T.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- I_ONE_WIRE, in, 1: sensed bus level. Asynchronous to clk.
- O_ONE_WIRE, out, 1: bus drive. 1 = release, 0 = pull low.
- I_TEMP, in, 16: temperature word. Latched when a conversion completes.
- O_CMD, out, 8: last command byte received.
- O_CMD_VALID, out, 1: one-cycle pulse when O_CMD updates.
- O_BUSY, out, 1: high while a conversion is running.

## Operation

Input conditioning:
- I_ONE_WIRE passes through a 2-FF synchroniser, then an edge detector for falling and rising edges.
- lowcnt counts consecutive low cycles and saturates at RESET_MIN_US·CLKS_PER_US.

Reset detection:
- When lowcnt reaches the reset threshold, the FSM enters RST_LOW from any state.
- Entry aborts any transfer and releases the bus.
- A conversion in progress keeps running.

State machine:
- IDLE: waits for a bus reset.
- RST_LOW: on the rising edge, go to PRES_WAIT.
- PRES_WAIT: after PRES_WAIT_US, go to PRES_DRIVE.
- PRES_DRIVE: O_ONE_WIRE = 0 for PRES_LEN_US, then go to ROM_CMD.
- ROM_CMD: receive 8 bits, LSB first. On each falling edge, sample the bus after SAMPLE_US; high = 1.
  - Byte 0xCC: go to FUNC_CMD.
  - Any other byte: go to IGNORE.
- FUNC_CMD: receive 8 bits the same way.
  - 0x44: start the conversion counter, set O_BUSY, go to CONV_POLL.
  - 0xBE: go to READ_SP.
  - Any other byte: go to IGNORE.
- CONV_POLL: each read slot (falling edge) returns O_BUSY inverted. Busy returns 0 (bus driven low for READ_HOLD_US); done returns 1 (bus released).
- READ_SP: transmit scratchpad bytes 0..8, LSB first.
  - Bit 0: drive low for READ_HOLD_US from the detected falling edge.
  - Bit 1: leave the bus released.
  - After 72 bits, go to IGNORE.
- IGNORE: release the bus and wait for the next reset.

Conversion:
- The counter runs CONV_US·CLKS_PER_US cycles.
- At terminal count: latch I_TEMP into the scratchpad, clear O_BUSY.

Scratchpad:
- Byte 0: T[7:0]. Byte 1: T[15:8].
- Bytes 2..7: fixed 4B 46 7F FF 0C 10.
- Byte 8: CRC8 of bytes 0..7, polynomial x^8+x^5+x^4+1, reflected, init 0x00.
- The CRC is computed serially while bytes 0..7 shift out, one bit per read slot, and byte 8 is sent from that register.

Command reporting:
- O_CMD / O_CMD_VALID update after each complete ROM or function byte.

## Timing

Reset values (rst is synchronous):
- O_ONE_WIRE = 1, O_CMD = 0x00, O_CMD_VALID = 0, O_BUSY = 0.
- FSM in IDLE, scratchpad temperature = 0x0550 (85 °C power-on value).
- rst asserted mid-drive releases the bus on the next clock.

Latencies:
- Bus edge to FSM reaction: 3 clk (2 synchroniser stages + 1 register).
- Presence fall occurs PRES_WAIT_US·CLKS_PER_US + 3 cycles after the bus rising edge.
- Read-slot low starts 3 clk after the master's falling edge. The master must sample no earlier than 4 clk after its own falling edge.
- O_CMD_VALID rises 1 clk after the 8th sample point.

Boundary conditions:
- A falling edge that arrives while a hold is still active is ignored.
- Reset detection has priority over slot processing in the same cycle.
- A second 0x44 while O_BUSY is high restarts the conversion counter.

## Structure

Package ow_pkg holds:
- the state enum;
- command constants CMD_SKIP_ROM = 0xCC, CMD_CONVERT = 0x44, CMD_READ_SP = 0xBE;
- scratchpad constant bytes 2..7;
- CRC8 polynomial 0x8C (reflected).

Sub-module ow_crc8: serial CRC8 with clear, bit-enable and 8-bit state output.

## Test plan

All scenarios use CLKS_PER_US = 1.

1. Bus low 500 cycles, then high → O_ONE_WIRE low for exactly 120 cycles, starting 33 cycles after the rise.
2. Reset, then write 0xCC, 0x44 → O_CMD_VALID pulses with 0xCC then 0x44; O_BUSY high for 750 cycles. Read slots during that window return 0; after it, they return 1.
3. I_TEMP = 0x0191 converted, then reset, 0xCC, 0xBE, 72 read slots → bytes 91 01 4B 46 7F FF 0C 10, and byte 8 equals the bench CRC8 model.
4. Reset, 0x33 → O_CMD = 0x33, then no further bus drive until the next reset.
5. Bus low 480 cycles during READ_SP bit 20 → transfer abandoned, presence pulse issued.
6. rst asserted mid presence pulse → O_ONE_WIRE = 1 on the next clk, FSM IDLE, O_BUSY = 0.

Source files
------------

// File: rtl/ow_pkg.sv
// Shared constants for the 1-Wire slave emulator: FSM encodings, command bytes,
// fixed scratchpad contents and the reflected Dallas CRC8 polynomial.
package ow_pkg;

    typedef logic [3:0] ow_state_t;

    localparam ow_state_t ST_IDLE       = 4'd0;
    localparam ow_state_t ST_RST_LOW    = 4'd1;
    localparam ow_state_t ST_PRES_WAIT  = 4'd2;
    localparam ow_state_t ST_PRES_DRIVE = 4'd3;
    localparam ow_state_t ST_ROM_CMD    = 4'd4;
    localparam ow_state_t ST_FUNC_CMD   = 4'd5;
    localparam ow_state_t ST_CONV_POLL  = 4'd6;
    localparam ow_state_t ST_READ_SP    = 4'd7;
    localparam ow_state_t ST_IGNORE     = 4'd8;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SP  = 8'hBE;

    localparam logic [7:0] SP_BYTE2 = 8'h4B;
    localparam logic [7:0] SP_BYTE3 = 8'h46;
    localparam logic [7:0] SP_BYTE4 = 8'h7F;
    localparam logic [7:0] SP_BYTE5 = 8'hFF;
    localparam logic [7:0] SP_BYTE6 = 8'h0C;
    localparam logic [7:0] SP_BYTE7 = 8'h10;

    localparam logic [7:0]  CRC8_POLY     = 8'h8C;
    localparam logic [15:0] TEMP_POWER_ON = 16'h0550;

endpackage

// File: rtl/ow_crc8.sv
// Serial Dallas/Maxim CRC8 (reflected form), one bit per enable, LSB-first data.
module ow_crc8
    import ow_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;
    assign fb = crc[0] ^ din;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {1'b0, crc[7:1]} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/ow_slave_emu.sv
// DS18B20-style 1-Wire slave: presence, Skip ROM, Convert T and Read Scratchpad,
// with the CRC byte accumulated serially while the scratchpad shifts out.
module ow_slave_emu
    import ow_pkg::*;
#(
    parameter int CLKS_PER_US  = 1,
    parameter int RESET_MIN_US = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_LEN_US  = 120,
    parameter int SAMPLE_US    = 30,
    parameter int READ_HOLD_US = 30,
    parameter int CONV_US      = 750
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_ONE_WIRE,
    output logic        O_ONE_WIRE,
    input  logic [15:0] I_TEMP,
    output logic [7:0]  O_CMD,
    output logic        O_CMD_VALID,
    output logic        O_BUSY
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int RST_CYC  = RESET_MIN_US * CLKS_PER_US;
    localparam int PW_CYC   = PRES_WAIT_US * CLKS_PER_US;
    localparam int PL_CYC   = PRES_LEN_US * CLKS_PER_US;
    localparam int SMP_CYC  = SAMPLE_US * CLKS_PER_US;
    localparam int RH_CYC   = READ_HOLD_US * CLKS_PER_US;
    localparam int CONV_CYC = CONV_US * CLKS_PER_US;
    localparam int T_MAX    = imax(imax(PW_CYC, PL_CYC), imax(SMP_CYC, RH_CYC));
    localparam int TW       = $clog2(T_MAX + 1);
    localparam int LW       = $clog2(RST_CYC + 1);
    localparam int CW       = $clog2(CONV_CYC + 1);

    localparam logic [TW-1:0] PW_END   = TW'(PW_CYC - 1);
    localparam logic [TW-1:0] PL_END   = TW'(PL_CYC - 1);
    localparam logic [TW-1:0] SMP_END  = TW'(SMP_CYC - 1);
    localparam logic [TW-1:0] RH_END   = TW'(RH_CYC - 1);
    localparam logic [LW-1:0] RST_THR  = LW'(RST_CYC);
    localparam logic [CW-1:0] CONV_END = CW'(CONV_CYC - 1);

    function automatic logic [7:0] sp_byte(input logic [2:0] idx, input logic [15:0] t);
        case (idx)
            3'd0:    return t[7:0];
            3'd1:    return t[15:8];
            3'd2:    return SP_BYTE2;
            3'd3:    return SP_BYTE3;
            3'd4:    return SP_BYTE4;
            3'd5:    return SP_BYTE5;
            3'd6:    return SP_BYTE6;
            default: return SP_BYTE7;
        endcase
    endfunction

    logic            sync_p0, sync_p1, bus_p2;
    logic            fall, rise;
    logic [LW-1:0]   lowcnt;
    logic            reset_hit;
    ow_state_t       state;
    logic [TW-1:0]   timer;
    logic            slot_act;
    logic [6:0]      bitcnt;
    logic [7:0]      shreg;
    logic            byte_vld_p0;
    logic [15:0]     temp_sp;
    logic [CW-1:0]   conv_cnt;
    logic            sp_bit, smp_now, read_slot, conv_start;
    logic            crc_clr, crc_en;
    logic [7:0]      crc_val;

    // Stage p0/p1: metastability synchroniser; p2: previous level for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            bus_p2  <= 1'b1;
        end else begin
            sync_p0 <= I_ONE_WIRE;
            sync_p1 <= sync_p0;
            bus_p2  <= sync_p1;
        end
    end

    assign fall = bus_p2 & ~sync_p1;
    assign rise = ~bus_p2 & sync_p1;

    always_ff @(posedge clk) begin
        if (rst || sync_p1) begin
            lowcnt <= '0;
        end else if (lowcnt != RST_THR) begin
            lowcnt <= lowcnt + LW'(1);
        end
    end

    // lowcnt holds the threshold through the rising-edge cycle, so a rise seen here ends the reset
    assign reset_hit = (lowcnt == RST_THR);

    always_comb begin
        sp_bit = 1'b1;
        if (state == ST_CONV_POLL) begin
            sp_bit = ~O_BUSY;
        end else if (!bitcnt[6]) begin
            sp_bit = sp_byte(bitcnt[5:3], temp_sp)[bitcnt[2:0]];
        end else begin
            sp_bit = crc_val[bitcnt[2:0]];
        end
    end

    assign smp_now    = !reset_hit && (state == ST_ROM_CMD || state == ST_FUNC_CMD)
                        && !byte_vld_p0 && slot_act && (timer == SMP_END);
    assign read_slot  = !reset_hit && fall && !slot_act
                        && (state == ST_CONV_POLL || (state == ST_READ_SP && bitcnt != 7'd72));
    assign conv_start = !reset_hit && (state == ST_FUNC_CMD) && byte_vld_p0
                        && (shreg == CMD_CONVERT);
    assign crc_clr    = (state != ST_READ_SP);
    assign crc_en     = read_slot && (state == ST_READ_SP) && !bitcnt[6];

    ow_crc8 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (sp_bit),
        .crc (crc_val)
    );

    always_ff @(posedge clk) begin
        if (smp_now) begin
            shreg <= {sync_p1, shreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            O_ONE_WIRE  <= 1'b1;
            O_CMD       <= 8'h00;
            O_CMD_VALID <= 1'b0;
            slot_act    <= 1'b0;
            timer       <= '0;
            bitcnt      <= '0;
            byte_vld_p0 <= 1'b0;
        end else begin
            O_CMD_VALID <= 1'b0;
            byte_vld_p0 <= 1'b0;
            if (reset_hit) begin
                state      <= rise ? ST_PRES_WAIT : ST_RST_LOW;
                O_ONE_WIRE <= 1'b1;
                slot_act   <= 1'b0;
                timer      <= '0;
                bitcnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_RST_LOW: begin
                        if (rise) begin
                            state <= ST_PRES_WAIT;
                            timer <= '0;
                        end
                    end
                    ST_PRES_WAIT: begin
                        if (timer == PW_END) begin
                            state      <= ST_PRES_DRIVE;
                            O_ONE_WIRE <= 1'b0;
                            timer      <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_PRES_DRIVE: begin
                        if (timer == PL_END) begin
                            state      <= ST_ROM_CMD;
                            O_ONE_WIRE <= 1'b1;
                            bitcnt     <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_ROM_CMD, ST_FUNC_CMD: begin
                        if (byte_vld_p0) begin
                            O_CMD       <= shreg;
                            O_CMD_VALID <= 1'b1;
                            bitcnt      <= '0;
                            if (state == ST_ROM_CMD) begin
                                state <= (shreg == CMD_SKIP_ROM) ? ST_FUNC_CMD : ST_IGNORE;
                            end else if (shreg == CMD_CONVERT) begin
                                state <= ST_CONV_POLL;
                            end else if (shreg == CMD_READ_SP) begin
                                state <= ST_READ_SP;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end else if (slot_act) begin
                            if (timer == SMP_END) begin
                                slot_act    <= 1'b0;
                                bitcnt      <= bitcnt + 7'd1;
                                byte_vld_p0 <= (bitcnt == 7'd7);
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end else if (fall) begin
                            slot_act <= 1'b1;
                            timer    <= '0;
                        end
                    end
                    ST_CONV_POLL, ST_READ_SP: begin
                        if (slot_act) begin
                            if (timer == RH_END) begin
                                slot_act   <= 1'b0;
                                O_ONE_WIRE <= 1'b1;
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end else if (state == ST_READ_SP && bitcnt == 7'd72) begin
                            state <= ST_IGNORE;
                        end else if (read_slot) begin
                            if (!sp_bit) begin
                                O_ONE_WIRE <= 1'b0;
                                slot_act   <= 1'b1;
                                timer      <= '0;
                            end
                            if (state == ST_READ_SP) begin
                                bitcnt <= bitcnt + 7'd1;
                            end
                        end
                    end
                    ST_IGNORE: O_ONE_WIRE <= 1'b1;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    // Conversion runs independently of bus resets; a repeated Convert T restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            O_BUSY   <= 1'b0;
            conv_cnt <= '0;
            temp_sp  <= TEMP_POWER_ON;
        end else if (conv_start) begin
            O_BUSY   <= 1'b1;
            conv_cnt <= '0;
        end else if (O_BUSY) begin
            if (conv_cnt == CONV_END) begin
                O_BUSY  <= 1'b0;
                temp_sp <= I_TEMP;
            end else begin
                conv_cnt <= conv_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ow_slave_emu.sv
// Directed bench for ow_slave_emu: acts as the 1-Wire master on a wired-AND bus.
module tb_ow_slave_emu;
    import ow_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_drv = 1'b1;
    logic        o_ow;
    logic        bus;
    logic [15:0] i_temp = 16'h0191;
    logic [7:0]  o_cmd;
    logic        o_cmd_valid;
    logic        o_busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  cmd_q[$];
    int          busy_run = 0;
    int          last_busy = 0;
    int          ow_low_cycles = 0;

    assign bus = m_drv & o_ow;

    always #5 clk = ~clk;

    ow_slave_emu dut (
        .clk         (clk),
        .rst         (rst),
        .I_ONE_WIRE  (bus),
        .O_ONE_WIRE  (o_ow),
        .I_TEMP      (i_temp),
        .O_CMD       (o_cmd),
        .O_CMD_VALID (o_cmd_valid),
        .O_BUSY      (o_busy)
    );

    always @(negedge clk) begin
        if (o_cmd_valid) cmd_q.push_back(o_cmd);
        if (!o_ow) ow_low_cycles++;
        if (o_busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8_model(input logic [63:0] data);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 64; i++) begin
            fb = c[0] ^ data[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic bus_reset(input int len, input string tag);
        int first_low;
        int nlow;
        first_low = -1;
        nlow = 0;
        @(negedge clk);
        m_drv = 1'b0;
        repeat (len) @(negedge clk);
        m_drv = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!o_ow) begin
                nlow++;
                if (first_low < 0) first_low = i;
            end
        end
        check({tag, "_pres_start"}, first_low, 33);
        check({tag, "_pres_len"}, nlow, 120);
    endtask

    task automatic write_bit(input logic b);
        @(negedge clk);
        m_drv = 1'b0;
        repeat (b ? 5 : 60) @(negedge clk);
        m_drv = 1'b1;
        repeat (b ? 65 : 10) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b);
        @(negedge clk);
        m_drv = 1'b0;
        @(negedge clk);
        m_drv = 1'b1;
        repeat (9) @(negedge clk);
        b = bus;
        repeat (59) @(negedge clk);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic read_scratchpad(input logic [63:0] exp_data, input logic [7:0] exp_crc,
                                   input string tag);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            read_byte(v);
            check($sformatf("%s_byte%0d", tag, i), v, exp_data[i*8 +: 8]);
        end
        read_byte(v);
        check({tag, "_crc"}, v, exp_crc);
    endtask

    initial begin
        logic        b;
        logic [7:0]  v;
        logic [63:0] sp_pon;
        logic [63:0] sp_191;
        sp_pon = 64'h10_0C_FF_7F_46_4B_05_50;
        sp_191 = 64'h10_0C_FF_7F_46_4B_01_91;

        repeat (5) @(negedge clk);
        check("rst_ow", o_ow, 1'b1);
        check("rst_cmd", o_cmd, 8'h00);
        check("rst_valid", o_cmd_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_state", dut.state, ST_IDLE);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: presence pulse shape
        bus_reset(500, "t1");

        // power-on scratchpad, well-known CRC 0x1C
        write_byte(CMD_SKIP_ROM);
        write_byte(CMD_READ_SP);
        read_scratchpad(sp_pon, 8'h1C, "pon");

        // 2: Convert T and busy polling
        bus_reset(500, "t2");
        cmd_q.delete();
        write_byte(8'hCC);
        write_byte(8'h44);
        check("t2_ncmd", cmd_q.size(), 2);
        if (cmd_q.size() == 2) begin
            check("t2_cmd0", cmd_q[0], 8'hCC);
            check("t2_cmd1", cmd_q[1], 8'h44);
        end
        check("t2_busy_on", o_busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            read_bit(b);
            check($sformatf("t2_poll_busy%0d", i), b, 1'b0);
        end
        for (int i = 0; i < 2000 && o_busy; i++) @(negedge clk);
        check("t2_busy_end", o_busy, 1'b0);
        @(negedge clk);
        check("t2_busy_len", last_busy, 750);
        for (int i = 0; i < 2; i++) begin
            read_bit(b);
            check($sformatf("t2_poll_done%0d", i), b, 1'b1);
        end

        // 3: read back converted temperature with CRC
        bus_reset(500, "t3");
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_scratchpad(sp_191, crc8_model(sp_191), "t3");
        read_bit(b);
        check("t3_after72", b, 1'b1);

        // 4: unknown ROM command leaves the bus alone
        bus_reset(500, "t4");
        cmd_q.delete();
        write_byte(8'h33);
        check("t4_cmd", o_cmd, 8'h33);
        check("t4_ncmd", cmd_q.size(), 1);
        ow_low_cycles = 0;
        write_byte(8'hFF);
        for (int i = 0; i < 4; i++) read_bit(b);
        check("t4_no_drive", ow_low_cycles, 0);

        // 5: bus reset in the middle of a scratchpad read
        bus_reset(500, "t5a");
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_byte(v);
        check("t5_b0", v, 8'h91);
        read_byte(v);
        check("t5_b1", v, 8'h01);
        for (int i = 0; i < 4; i++) read_bit(b);
        bus_reset(480, "t5");
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_byte(v);
        check("t5_restart_b0", v, 8'h91);

        // 6: rst during presence with a conversion running
        bus_reset(500, "t6a");
        write_byte(8'hCC);
        write_byte(8'h44);
        @(negedge clk);
        m_drv = 1'b0;
        repeat (500) @(negedge clk);
        m_drv = 1'b1;
        for (int i = 0; i < 200 && o_ow; i++) @(negedge clk);
        check("t6_pres_seen", o_ow, 1'b0);
        check("t6_busy_kept", o_busy, 1'b1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_ow", o_ow, 1'b1);
        check("t6_state", dut.state, ST_IDLE);
        check("t6_busy", o_busy, 1'b0);
        check("t6_cmd", o_cmd, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
